// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler states and word/frame sizing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } sched_state_t;

    localparam int UART_WORD_W           = 9;
    localparam int UART_FRAME_CYCLES_DEF = 14;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDW-1:0]     winner_idx,
    output logic               winner_vld
);

    always_comb begin
        int j;
        j          = 0;
        winner_oh  = '0;
        winner_idx = '0;
        winner_vld = 1'b0;
        // k starts at 1 so the last winner is searched last
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!winner_vld && req_valid[j]) begin
                winner_vld    = 1'b1;
                winner_oh[j]  = 1'b1;
                winner_idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters: round-robin grant, timed frame, idle gap.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int FRAME_CYCLES = UART_FRAME_CYCLES_DEF,
    parameter  int GAP_CYCLES   = 2,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                           txclk,
    input  logic                           reset,
    input  logic                           sched_en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_enable,
    output logic [UART_WORD_W-1:0]         tx_data,
    output logic                           busy,
    output logic [IDW-1:0]                 grant_id,
    output logic                           frame_done,
    output logic [15:0]                    frame_count
);

    localparam int TMAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    sched_state_t           state;
    logic [TW-1:0]          timer;
    logic [NUM_REQ-1:0]     win_oh;
    logic [IDW-1:0]         win_idx;
    logic                   win_vld;
    logic [UART_WORD_W-1:0] win_word;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid  (req_valid),
        .ptr        (grant_id),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .winner_vld (win_vld)
    );

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win_oh[i]) win_word = req_data[i*UART_WORD_W +: UART_WORD_W];
    end

    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            req_ready   <= '0;
            tx_enable   <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            grant_id    <= IDW'(NUM_REQ - 1);
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            req_ready  <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sched_en && win_vld) begin
                        tx_data   <= win_word;
                        grant_id  <= win_idx;
                        req_ready <= win_oh;
                        tx_enable <= 1'b1;
                        busy      <= 1'b1;
                        timer     <= TW'(FRAME_CYCLES - 1);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (timer == '0) begin
                        tx_enable   <= 1'b0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        if (GAP_CYCLES > 0) begin
                            timer <= TW'(GAP_LOAD);
                            state <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: directed table, rotation/spacing, enable/reset corners, random vs. timing model, wrap, no-gap build.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int F  = 14;
    localparam int G  = 2;
    localparam int W  = 9;
    localparam int NB = 2;
    localparam int FB = 5;

    logic           txclk = 1'b0;
    logic           reset;
    logic           sched_en;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_enable;
    logic [W-1:0]   tx_data;
    logic           busy;
    logic [1:0]     grant_id;
    logic           frame_done;
    logic [15:0]    frame_count;

    logic            sched_en_b;
    logic [NB-1:0]   req_valid_b;
    logic [NB*W-1:0] req_data_b;
    logic [NB-1:0]   req_ready_b;
    logic            tx_enable_b;
    logic [W-1:0]    tx_data_b;
    logic            busy_b;
    logic [0:0]      grant_id_b;
    logic            frame_done_b;
    logic [15:0]     frame_count_b;

    always #5 txclk = ~txclk;

    uart_tx_scheduler #(.NUM_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(G)) dut (
        .txclk(txclk), .reset(reset), .sched_en(sched_en), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .tx_enable(tx_enable), .tx_data(tx_data),
        .busy(busy), .grant_id(grant_id), .frame_done(frame_done), .frame_count(frame_count)
    );

    uart_tx_scheduler #(.NUM_REQ(NB), .FRAME_CYCLES(FB), .GAP_CYCLES(0)) dut_b (
        .txclk(txclk), .reset(reset), .sched_en(sched_en_b), .req_valid(req_valid_b),
        .req_data(req_data_b), .req_ready(req_ready_b), .tx_enable(tx_enable_b), .tx_data(tx_data_b),
        .busy(busy_b), .grant_id(grant_id_b), .frame_done(frame_done_b), .frame_count(frame_count_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge txclk);
        @(negedge txclk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [W-1:0] base;
        logic [N-1:0] exp_ready;
        int           exp_gid;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [W-1:0] words [N];
        int           order [8];
        int           rise  [8];
        int           gcount, nrise, hi, fd, pulses;
        logic         prev_en, got;

        tbl[0] = '{4'b0100, 9'h1A3, 4'b0100, 2};
        tbl[1] = '{4'b1111, 9'h040, 4'b1000, 3};
        tbl[2] = '{4'b0011, 9'h0F0, 4'b0001, 0};
        tbl[3] = '{4'b0011, 9'h155, 4'b0010, 1};
        tbl[4] = '{4'b1000, 9'h0AA, 4'b1000, 3};
        tbl[5] = '{4'b0110, 9'h1F0, 4'b0010, 1};

        reset = 1'b0; sched_en = 1'b0; req_valid = '0; req_data = '0;
        sched_en_b = 1'b0; req_valid_b = '0; req_data_b = '0;

        // reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_tx_enable", tx_enable, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_grant_id", grant_id, N - 1);
        @(negedge txclk);
        reset = 1'b0;

        // table-driven single grants
        for (int v = 0; v < 6; v++) begin
            @(negedge txclk);
            sched_en  = 1'b1;
            req_valid = tbl[v].valid;
            for (int i = 0; i < N; i++) req_data[i*W +: W] = tbl[v].base + W'(i);
            @(posedge txclk); #1;
            chk($sformatf("tbl%0d_ready", v), req_ready, tbl[v].exp_ready);
            chk($sformatf("tbl%0d_tx_data", v), tx_data, tbl[v].base + W'(tbl[v].exp_gid));
            chk($sformatf("tbl%0d_grant_id", v), grant_id, tbl[v].exp_gid);
            hi = tx_enable ? 1 : 0;
            fd = 0;
            @(negedge txclk);
            req_valid = '0;
            for (int c = 0; c < F + G; c++) begin
                @(posedge txclk); #1;
                if (c == 0) chk($sformatf("tbl%0d_ready_pulse", v), req_ready, 0);
                if (tx_enable) hi++;
                if (frame_done) fd++;
            end
            chk($sformatf("tbl%0d_enable_len", v), hi, F);
            chk($sformatf("tbl%0d_done_pulses", v), fd, 1);
            chk($sformatf("tbl%0d_frame_count", v), frame_count, v + 1);
            chk($sformatf("tbl%0d_busy_end", v), busy, 0);
        end

        // all requesters held valid: rotation and grant spacing
        do_reset();
        for (int i = 0; i < N; i++) words[i] = 9'h100 + W'(i);
        req_valid = '1; sched_en = 1'b1;
        gcount = 0; nrise = 0; prev_en = 1'b0;
        for (int c = 0; c < 8 * 17 + 40 && gcount < 8; c++) begin
            for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
            @(posedge txclk); #1;
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++)
                    if (req_ready[i]) begin
                        order[gcount] = i;
                        chk($sformatf("rot_data%0d", gcount), tx_data, words[i]);
                        words[i] = W'($urandom);
                    end
                gcount++;
            end
            if (tx_enable && !prev_en && nrise < 8) begin
                rise[nrise] = c;
                nrise++;
            end
            prev_en = tx_enable;
            @(negedge txclk);
        end
        chk("rot_grants", gcount, 8);
        for (int k = 0; k < 8 && k < gcount; k++) chk($sformatf("rot_order%0d", k), order[k], k % N);
        for (int k = 1; k < 8 && k < nrise; k++) chk($sformatf("rot_spacing%0d", k), rise[k] - rise[k-1], F + G + 1);

        // reset five cycles into a frame
        for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge txclk); #1;
            if (req_ready != '0) got = 1'b1;
        end
        chk("rstmid_grant_seen", got, 1);
        repeat (5) @(posedge txclk);
        #3 reset = 1'b1;
        #1;
        chk("rstmid_tx_enable", tx_enable, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_frame_count", frame_count, 0);
        @(negedge txclk);
        reset = 1'b0;
        @(posedge txclk); #1;
        chk("rstmid_first_winner", req_ready, 4'b0001);
        chk("rstmid_grant_id", grant_id, 0);

        // sched_en dropped mid-SEND
        @(negedge txclk);
        req_valid = '0;
        do_reset();
        req_valid = 4'b0010; req_data = '0; req_data[W +: W] = 9'h0C3; sched_en = 1'b1;
        @(posedge txclk); #1;
        chk("en_grant", req_ready, 4'b0010);
        repeat (3) @(negedge txclk);
        sched_en = 1'b0;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge txclk); #1;
            if (req_ready != '0) pulses++;
        end
        chk("en_no_grants", pulses, 0);
        chk("en_frame_count", frame_count, 1);
        chk("en_tx_enable_low", tx_enable, 0);
        chk("en_busy_low", busy, 0);
        @(negedge txclk);
        sched_en = 1'b1;
        @(posedge txclk); #1;
        chk("en_regrant", req_ready, 4'b0010);

        // randomized traffic against an arithmetic timing model
        @(negedge txclk);
        req_valid = '0;
        do_reset();
        begin
            logic         pend [N];
            logic [W-1:0] pw   [N];
            int           next_free, last, ptr, n, w;
            logic [15:0]  efc;
            logic [N-1:0] eready;
            logic [W-1:0] etx;
            logic         en;
            next_free = 0; last = -1; ptr = N - 1; n = 0; efc = 0; etx = '0;
            for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pw[i] = '0; end
            for (int c = 0; c < 1500; c++) begin
                en = ($urandom_range(0, 9) != 0);
                sched_en = en;
                for (int i = 0; i < N; i++) begin
                    req_valid[i] = pend[i];
                    req_data[i*W +: W] = pw[i];
                end
                @(posedge txclk);
                eready = '0;
                if (en && req_valid != '0 && n >= next_free) begin
                    w = -1;
                    for (int k = 1; k <= N; k++)
                        if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
                    eready[w] = 1'b1;
                    ptr = w; last = n; next_free = n + F + G + 1; etx = pw[w];
                end
                if (last >= 0 && n == last + F) efc = efc + 16'd1;
                #1;
                chk("rnd_req_ready", req_ready, eready);
                chk("rnd_tx_enable", tx_enable, (last >= 0 && n - last < F));
                chk("rnd_busy", busy, (last >= 0 && n - last < F + G));
                chk("rnd_frame_done", frame_done, (last >= 0 && n - last == F));
                chk("rnd_frame_count", frame_count, efc);
                chk("rnd_grant_id", grant_id, ptr);
                if (last >= 0 && n - last < F) chk("rnd_tx_data", tx_data, etx);
                n++;
                for (int i = 0; i < N; i++) begin
                    if (eready[i]) pend[i] = 1'b0;
                    if (!pend[i] && $urandom_range(0, 5) == 0) begin
                        pend[i] = 1'b1;
                        pw[i]   = W'($urandom);
                    end
                end
                @(negedge txclk);
            end
        end

        // frame_count wrap
        req_valid = '0;
        repeat (20) @(negedge txclk);
        force dut.frame_count = 16'hFFFF;
        @(negedge txclk);
        release dut.frame_count;
        #1;
        chk("wrap_preload", frame_count, 16'hFFFF);
        @(negedge txclk);
        sched_en = 1'b1; req_valid = 4'b0001;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge txclk); #1;
            if (req_ready != '0) req_valid = '0;
            if (frame_done) begin
                got = 1'b1;
                chk("wrap_frame_count", frame_count, 0);
            end
        end
        chk("wrap_done_seen", got, 1);

        // no-gap build: one idle cycle between frames, alternating grants
        @(negedge txclk);
        do_reset();
        sched_en_b = 1'b1; req_valid_b = '1; req_data_b = {9'h0B2, 9'h1C1};
        begin
            int           run;
            logic         prev, seen;
            logic [NB-1:0] exp_r;
            run = 0; prev = 1'b0; seen = 1'b0; exp_r = 2'b01;
            for (int c = 0; c < 40; c++) begin
                @(posedge txclk); #1;
                if (req_ready_b != '0) begin
                    chk("nogap_grant", req_ready_b, exp_r);
                    exp_r = ~exp_r;
                end
                if (tx_enable_b == prev) run++;
                else begin
                    if (prev) begin
                        chk("nogap_high_len", run, FB);
                        seen = 1'b1;
                    end else if (seen) chk("nogap_low_len", run, 1);
                    run  = 1;
                    prev = tx_enable_b;
                end
            end
            chk("nogap_frames", frame_count_b >= 16'd5, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one `uart` transmitter between `NUM_REQ` requesters, all on the transmit clock domain. It grants one 9-bit word at a time and drives `tx_data`/`tx_enable` into the `uart` TX port. It times each frame with a cycle counter, because the transmitter exposes no done flag. It then inserts a programmable idle gap before the next grant.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `FRAME_CYCLES`, 14: `txclk` cycles `tx_enable` is held high per word. Covers start, 9 data bits, parity, stop and `tx_done`. Must be ≥1.
- `GAP_CYCLES`, 2: idle `txclk` cycles after a frame, with `tx_enable` low, before the next grant. 0 is legal.
- `txclk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `sched_en`  in  1  when low, no new grants; the frame in flight completes.
- `req_valid`  in  NUM_REQ  requester i has a word pending.
- `req_data`  in  9*NUM_REQ  word of requester i at bits [9i+8:9i].
- `req_ready`  out  NUM_REQ  one-cycle pulse: word of requester i consumed.
- `tx_enable`  out  1  to `uart.tx_enable`.
- `tx_data`  out  9  to `uart.tx_data`; stable while `tx_enable` is high.
- `busy`  out  1  high in SEND and GAP.
- `grant_id`  out  $clog2(NUM_REQ)  index of the last granted requester.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.
- `frame_count`  out  16  number of completed frames; wraps 0xFFFF→0.

## Operation
- States: IDLE, SEND, GAP. All outputs are registered.
- Reset (async) values:
  - state IDLE; `req_ready`=0, `tx_enable`=0, `tx_data`=0, `busy`=0, `frame_done`=0, `frame_count`=0.
  - `grant_id`=NUM_REQ-1, so requester 0 has top priority first.
  - Internal timer=0.
- IDLE, on a clock edge with `sched_en`=1 and any `req_valid` bit set:
  - Winner i = first set bit of `req_valid`, searching from `grant_id`+1 upward, mod NUM_REQ.
  - `tx_data`<=word i, `grant_id`<=i, `req_ready[i]`<=1, `tx_enable`<=1, `busy`<=1.
  - timer<=FRAME_CYCLES-1, state<=SEND.
- SEND:
  - `req_ready` returns to 0 after one cycle; `req_valid` is ignored.
  - The timer decrements each cycle. At timer==0:
    - `tx_enable`<=0, `frame_done`<=1 for one cycle, `frame_count`<=`frame_count`+1.
    - If GAP_CYCLES>0: timer<=GAP_CYCLES-1, state<=GAP. Otherwise state<=IDLE and `busy`<=0.
- GAP: the timer decrements. At timer==0: state<=IDLE, `busy`<=0.
- Requester handshake:
  - Holds `req_valid` and data until it sees `req_ready`.
  - Deasserts `req_valid` or presents the next word in the cycle after `req_ready`.
  - A valid dropped before it is granted is never granted.
- Arithmetic: timer width is $clog2(max(FRAME_CYCLES,GAP_CYCLES)+1). `frame_count` is a plain 16-bit increment.

## Timing
- Grant latency: `req_valid` sampled high at edge k (state IDLE) → `tx_enable`, `tx_data` and `req_ready` high after edge k.
- `tx_enable` stays high exactly FRAME_CYCLES cycles. `frame_done` is high in the first cycle with `tx_enable` low.
- Back-to-back grant spacing: FRAME_CYCLES+GAP_CYCLES+1 cycles between `tx_enable` rising edges, because one IDLE cycle is needed to arbitrate.
- Simultaneous valids: exactly one grant per IDLE cycle, rotating. With all valids held high, grant order is 0,1,2,3,0,… for NUM_REQ=4.
- `sched_en` falling during SEND or GAP: the frame and gap complete normally, then the scheduler stays in IDLE.
- Reset mid-frame: `tx_enable` drops immediately (asynchronous) and the word is lost. The requester has already seen `req_ready`, so no retry is made.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `sched_state_t` {IDLE, SEND, GAP};
  - `UART_WORD_W`=9;
  - `UART_FRAME_CYCLES_DEF`=14.
- One sub-module, `rr_arbiter`:
  - Combinational.
  - Inputs: `req_valid` and the `grant_id` pointer. Outputs: a one-hot winner and its index.
  - Instantiated once; the FSM, timer and counters live in `uart_tx_scheduler`.

## Test plan
- Reset, then requester 2 only, valid with data 0x1A5 → one-cycle `req_ready`=0b0100; `tx_data`=0x1A5 with `tx_enable` high 14 cycles; `frame_done` pulse; `frame_count`=1; `grant_id`=2.
- All 4 valid and held, 8 grants → grant order 0,1,2,3,0,1,2,3; rising edges of `tx_enable` every 17 cycles (14+2+1).
- `sched_en` dropped mid-SEND → frame completes, `frame_count` increments, no further `req_ready` until `sched_en`=1.
- GAP_CYCLES=0 build, 2 requesters continuously valid → `tx_enable` low for exactly 1 cycle between frames.
- `reset` asserted 5 cycles into SEND → same cycle: `tx_enable`=0, `busy`=0, `frame_count`=0; after release, requester 0 wins first.
- Preload `frame_count` path to 0xFFFF (force or 65535 frames) → next `frame_done` yields `frame_count`=0.
